// File: rtl/clk_pkg.sv
// Shared clocking/reset definitions: lock sequencer state encoding, default
// timing constants and the cycle-counter sizing helper.
package clk_pkg;

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } lock_seq_state_e;

    localparam int unsigned PLL_RST_CYC_DEF      = 16;
    localparam int unsigned LOCK_STABLE_CYC_DEF  = 1024;
    localparam int unsigned LOCK_TIMEOUT_CYC_DEF = 500000;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Width that holds every "N-1" terminal count; never below one bit.
    function automatic int unsigned cyc_cnt_w(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned w;
        w = $clog2(max3(a, b, c));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous status bit; output is
// the input delayed by SYNC_STAGES clocks, all flops reset to 0.
module sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_d};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_seq.sv
// PLL lock sequencer: holds the PLL in reset, qualifies synchronized lock
// over a stable window, then releases fabric reset; re-arms on loss/timeout.
module pll_lock_seq
    import clk_pkg::*;
#(
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned PLL_RST_CYC      = PLL_RST_CYC_DEF,
    parameter int unsigned LOCK_STABLE_CYC  = LOCK_STABLE_CYC_DEF,
    parameter int unsigned LOCK_TIMEOUT_CYC = LOCK_TIMEOUT_CYC_DEF,
    parameter int unsigned CNT_W            = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_lock,
    input  logic             i_clr_cnt,
    output logic             o_pll_reset,
    output logic             o_rst,
    output logic             o_ready,
    output logic [CNT_W-1:0] o_loss_cnt,
    output logic [CNT_W-1:0] o_timeout_cnt,
    output logic [1:0]       o_state
);

    localparam int unsigned CYC_W = cyc_cnt_w(PLL_RST_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC);

    localparam logic [CYC_W-1:0] PLL_RST_LAST = CYC_W'(PLL_RST_CYC - 1);
    localparam logic [CYC_W-1:0] STABLE_LAST  = CYC_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT_CYC - 1);

    logic lock_s;

    lock_seq_state_e  state_q,       state_d;
    logic [CYC_W-1:0] cyc_cnt_q,     cyc_cnt_d;
    logic [CNT_W-1:0] loss_cnt_q,    loss_cnt_d;
    logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
    logic             pll_reset_q,   pll_reset_d;
    logic             rst_q,         rst_d;
    logic             ready_q,       ready_d;
    logic             loss_evt;
    logic             timeout_evt;

    sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_lock),
        .o_q   (lock_s)
    );

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d     = state_q;
        loss_evt    = 1'b0;
        timeout_evt = 1'b0;

        unique case (state_q)
            S_PLL_RST: begin
                if (cyc_cnt_q == PLL_RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                end else if (cyc_cnt_q == TIMEOUT_LAST) begin
                    state_d     = S_PLL_RST;
                    timeout_evt = 1'b1;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (cyc_cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_d  = S_PLL_RST;
                    loss_evt = 1'b1;
                end
            end
            default: state_d = S_PLL_RST;
        endcase

        // Counter value is meaningless in S_RUN, so wrapping there is harmless.
        cyc_cnt_d = (state_d != state_q) ? '0 : cyc_cnt_q + CYC_W'(1);

        // Outputs are registered from the next state, matching a decode of state_q.
        pll_reset_d = (state_d == S_PLL_RST);
        rst_d       = (state_d != S_RUN);
        ready_d     = (state_d == S_RUN);
    end

    // Clear beats increment; increments saturate at all-ones.
    always_comb begin
        loss_cnt_d    = loss_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        if (i_clr_cnt) begin
            loss_cnt_d    = '0;
            timeout_cnt_d = '0;
        end else begin
            if (loss_evt && (loss_cnt_q != '1)) begin
                loss_cnt_d = loss_cnt_q + CNT_W'(1);
            end
            if (timeout_evt && (timeout_cnt_q != '1)) begin
                timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= S_PLL_RST;
            cyc_cnt_q     <= '0;
            loss_cnt_q    <= '0;
            timeout_cnt_q <= '0;
            pll_reset_q   <= 1'b1;
            rst_q         <= 1'b1;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cyc_cnt_q     <= cyc_cnt_d;
            loss_cnt_q    <= loss_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            pll_reset_q   <= pll_reset_d;
            rst_q         <= rst_d;
            ready_q       <= ready_d;
        end
    end

    assign o_pll_reset   = pll_reset_q;
    assign o_rst         = rst_q;
    assign o_ready       = ready_q;
    assign o_loss_cnt    = loss_cnt_q;
    assign o_timeout_cnt = timeout_cnt_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq: a countdown/history model checked every
// cycle, plus hand-computed timing expectations for each scenario.
module tb_pll_lock_seq;

    localparam int unsigned SYNC      = 2;
    localparam int unsigned RST_CYC   = 4;
    localparam int unsigned STAB_CYC  = 8;
    localparam int unsigned TOUT_CYC  = 32;
    localparam int unsigned CW        = 4;
    localparam int unsigned CNT_MAX   = 15;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_lock = 1'b0;
    logic          i_clr_cnt = 1'b0;
    logic          o_pll_reset;
    logic          o_rst;
    logic          o_ready;
    logic [CW-1:0] o_loss_cnt;
    logic [CW-1:0] o_timeout_cnt;
    logic [1:0]    o_state;

    int n_vec = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    pll_lock_seq #(
        .SYNC_STAGES      (SYNC),
        .PLL_RST_CYC      (RST_CYC),
        .LOCK_STABLE_CYC  (STAB_CYC),
        .LOCK_TIMEOUT_CYC (TOUT_CYC),
        .CNT_W            (CW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_lock        (i_lock),
        .i_clr_cnt     (i_clr_cnt),
        .o_pll_reset   (o_pll_reset),
        .o_rst         (o_rst),
        .o_ready       (o_ready),
        .o_loss_cnt    (o_loss_cnt),
        .o_timeout_cnt (o_timeout_cnt),
        .o_state       (o_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: phase 0..3 = pll reset / waiting / qualifying / running; m_left
    // counts down the cycles still allowed in the current phase.
    int unsigned m_phase;
    int unsigned m_left;
    int unsigned m_loss;
    int unsigned m_tout;
    bit          m_valid = 1'b0;
    bit          lock_hist[$];

    function automatic int unsigned dwell(input int unsigned ph);
        case (ph)
            0:       return RST_CYC;
            1:       return TOUT_CYC;
            2:       return STAB_CYC;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit ls;
        bit loss_ev;
        bit tout_ev;
        if (i_rst) begin
            m_phase = 0;
            m_left  = dwell(0);
            m_loss  = 0;
            m_tout  = 0;
            lock_hist.delete();
            for (int i = 0; i < SYNC; i++) lock_hist.push_back(1'b0);
            m_valid = 1'b1;
        end else if (m_valid) begin
            ls = lock_hist.pop_front();
            lock_hist.push_back(i_lock);
            loss_ev = 1'b0;
            tout_ev = 1'b0;
            case (m_phase)
                0: if (m_left == 1) begin m_phase = 1; m_left = dwell(1); end
                   else m_left--;
                1: if (ls) begin m_phase = 2; m_left = dwell(2); end
                   else if (m_left == 1) begin m_phase = 0; m_left = dwell(0); tout_ev = 1'b1; end
                   else m_left--;
                2: if (!ls) begin m_phase = 1; m_left = dwell(1); end
                   else if (m_left == 1) m_phase = 3;
                   else m_left--;
                default: if (!ls) begin m_phase = 0; m_left = dwell(0); loss_ev = 1'b1; end
            endcase
            if (i_clr_cnt) begin
                m_loss = 0;
                m_tout = 0;
            end else begin
                if (loss_ev && m_loss < CNT_MAX) m_loss++;
                if (tout_ev && m_tout < CNT_MAX) m_tout++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_state",     o_state,       m_phase);
            check("cyc_pll_reset", o_pll_reset,   m_phase == 0);
            check("cyc_rst",       o_rst,         m_phase != 3);
            check("cyc_ready",     o_ready,       m_phase == 3);
            check("cyc_loss_cnt",  o_loss_cnt,    m_loss);
            check("cyc_tout_cnt",  o_timeout_cnt, m_tout);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] target, input int budget);
        bit found;
        found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (o_state == target) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
        if (!found) check("wait_state_timeout", o_state, target);
    endtask

    task automatic reach_run();
        wait_state(2'd1, 40);
        i_lock = 1'b1;
        wait_state(2'd3, 40);
    endtask

    initial begin
        int hi;
        int lo;

        tick(3);
        check("rst_state",     o_state, 0);
        check("rst_pll_reset", o_pll_reset, 1);
        check("rst_o_rst",     o_rst, 1);
        check("rst_ready",     o_ready, 0);
        check("rst_loss",      o_loss_cnt, 0);
        check("rst_tout",      o_timeout_cnt, 0);
        i_rst = 1'b0;

        // No lock at all: two full reset/timeout attempts.
        for (int a = 1; a <= 2; a++) begin
            hi = 0;
            lo = 0;
            for (int k = 0; k < 100 && o_pll_reset; k++) begin hi++; tick(1); end
            for (int k = 0; k < 100 && !o_pll_reset; k++) begin lo++; tick(1); end
            check("pll_reset_high_cycles", hi, 4);
            check("wait_lock_cycles", lo, 32);
            check("timeout_cnt", o_timeout_cnt, a);
            check("o_rst_held", o_rst, 1);
        end

        // Lock arrives in S_WAIT_LOCK, then glitches during qualification.
        wait_state(2'd1, 20);
        tick(3);
        i_lock = 1'b1;
        tick(2);
        check("sync_latency_still_wait", o_state, 1);
        tick(1);
        check("enter_stable", o_state, 2);
        tick(4);
        i_lock = 1'b0;
        tick(1);
        i_lock = 1'b1;
        tick(2);
        check("glitch_back_to_wait", o_state, 1);
        check("glitch_tout_unchanged", o_timeout_cnt, 2);
        check("glitch_loss_unchanged", o_loss_cnt, 0);
        tick(1);
        check("reenter_stable", o_state, 2);
        tick(7);
        check("stable_window_not_done", o_rst, 1);
        tick(1);
        check("run_state", o_state, 3);
        check("run_o_rst", o_rst, 0);
        check("run_ready", o_ready, 1);

        // Lock loss in S_RUN.
        i_lock = 1'b0;
        tick(2);
        check("loss_rst_not_yet", o_rst, 0);
        tick(1);
        check("loss_rst_high", o_rst, 1);
        check("loss_state", o_state, 0);
        check("loss_pll_reset", o_pll_reset, 1);
        check("loss_cnt_1", o_loss_cnt, 1);
        tick(3);
        check("loss_pll_reset_4th", o_pll_reset, 1);
        tick(1);
        check("loss_pll_reset_done", o_pll_reset, 0);

        // 19 more losses -> saturation at 15.
        for (int l = 0; l < 19; l++) begin
            reach_run();
            i_lock = 1'b0;
            wait_state(2'd0, 10);
        end
        check("loss_cnt_saturated", o_loss_cnt, 15);

        // Clear coincides with a loss event.
        reach_run();
        i_lock = 1'b0;
        tick(2);
        i_clr_cnt = 1'b1;
        tick(1);
        i_clr_cnt = 1'b0;
        check("clr_wins_loss", o_loss_cnt, 0);
        check("clr_tout", o_timeout_cnt, 0);
        check("clr_state", o_state, 0);

        // Reset pulse while running.
        wait_state(2'd1, 20);
        reach_run();
        i_lock = 1'b0;
        wait_state(2'd0, 10);
        check("pre_rst_loss", o_loss_cnt, 1);
        reach_run();
        i_rst = 1'b1;
        tick(1);
        i_rst = 1'b0;
        check("midrst_state", o_state, 0);
        check("midrst_o_rst", o_rst, 1);
        check("midrst_pll_reset", o_pll_reset, 1);
        check("midrst_ready", o_ready, 0);
        check("midrst_loss", o_loss_cnt, 0);
        check("midrst_tout", o_timeout_cnt, 0);
        tick(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
